// File: rtl/ai_accelerator_core_if.sv
// rtl/ai_accelerator_core_if.sv - host bus bundle for the matrix-multiply engine
interface ai_accelerator_core_if;
    logic [31:0] wishbone_addr_i;
    logic        wishbone_we_i;
    logic [31:0] wishbone_data_i;
    logic [31:0] wishbone_data_o;
    logic        wishbone_ack;

    modport master (
        output wishbone_addr_i,
        output wishbone_we_i,
        output wishbone_data_i,
        input  wishbone_data_o,
        input  wishbone_ack
    );

    modport slave (
        input  wishbone_addr_i,
        input  wishbone_we_i,
        input  wishbone_data_i,
        output wishbone_data_o,
        output wishbone_ack
    );
endinterface

// File: rtl/ai_accelerator_core.sv
// rtl/ai_accelerator_core.sv - N x N matrix-multiply engine, one MAC per clock (option: AI_ACC_SATURATE_EN)
module ai_accelerator_core #(
    parameter int N = 4
) (
    input  logic                 wishbone_clk_i,
    input  logic                 wishbone_rst_i,
    ai_accelerator_core_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [31:0]     acc_q, acc_d;
    logic            done_q, done_d;
    logic [31:0]     data_o_q, data_o_d;
    logic            ack_q, ack_d;
    logic [15:0]     a_q [N][N];
    logic [15:0]     a_d [N][N];
    logic [15:0]     b_q [N][N];
    logic [15:0]     b_d [N][N];
    logic [31:0]     c_q [N][N];
    logic [31:0]     c_d [N][N];

    logic [1:0]      region;
    logic [LW-1:0]   row, col;
    logic            busy;
    logic [31:0]     prod;
    logic [31:0]     acc_next;
    logic            unused_bits;

    assign region      = bus.wishbone_addr_i[31:30];
    assign row         = bus.wishbone_addr_i[8 +: LW];
    assign col         = bus.wishbone_addr_i[0 +: LW];
    assign unused_bits = ^{bus.wishbone_addr_i[29:8+LW], bus.wishbone_addr_i[7:LW],
                           bus.wishbone_data_i[31:16]};
    assign busy        = (state_q != S_IDLE);

    // Exact 16x16 product of the current term
    assign prod = {16'b0, a_q[i_q][k_q]} * {16'b0, b_q[k_q][j_q]};

`ifdef AI_ACC_SATURATE_EN
    logic [32:0] sum_wide;
    // Clamp on carry-out; an all-ones accumulator stays all-ones for the rest of the element
    assign sum_wide = {1'b0, acc_q} + {1'b0, prod};
    assign acc_next = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`else
    assign acc_next = acc_q + prod;
`endif

    assign bus.wishbone_data_o = data_o_q;
    assign bus.wishbone_ack    = ack_q;

    // Next state: MAC sequencing first, then the bus access sampled this edge
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        done_d   = done_q;
        data_o_d = data_o_q;
        ack_d    = 1'b1;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;

        case (state_q)
            S_MAC: begin
                if (k_q == LAST) begin
                    c_d[i_q][j_q] = acc_next;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) state_d = S_DONE;
                        else             i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_next;
                    k_d   = k_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: ;
        endcase

        if (bus.wishbone_we_i) begin
            case (region)
                2'b00: begin
                    if (bus.wishbone_data_i[0]) begin
                        if (!busy) begin
                            state_d = S_MAC;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            acc_d   = '0;
                            done_d  = 1'b0;
                        end else begin
                            ack_d = 1'b0;
                        end
                    end
                end
                2'b01: begin
                    if (!busy) a_d[row][col] = bus.wishbone_data_i[15:0];
                    else       ack_d = 1'b0;
                end
                2'b10: begin
                    if (!busy) b_d[row][col] = bus.wishbone_data_i[15:0];
                    else       ack_d = 1'b0;
                end
                default: ;
            endcase
        end else begin
            case (region)
                2'b00:   data_o_d = {30'b0, done_q, busy};
                2'b01:   data_o_d = {16'b0, a_q[row][col]};
                2'b10:   data_o_d = {16'b0, b_q[row][col]};
                default: data_o_d = c_q[row][col];
            endcase
        end
    end

    // State registers, all cleared by reset
    always_ff @(posedge wishbone_clk_i or negedge wishbone_rst_i) begin
        if (!wishbone_rst_i) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            data_o_q <= '0;
            ack_q    <= 1'b0;
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            c_q      <= '{default: '0};
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            data_o_q <= data_o_d;
            ack_q    <= ack_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
        end
    end
endmodule

// File: tb/tb_ai_accelerator_core.sv
// tb/tb_ai_accelerator_core.sv - scoreboard bench for ai_accelerator_core
module tb_ai_accelerator_core;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ai_accelerator_core_if bus ();

    ai_accelerator_core #(.N(N)) dut (
        .wishbone_clk_i (clk),
        .wishbone_rst_i (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ack;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    typedef struct {
        logic        ack;
        logic [31:0] data;
    } obs_t;

    exp_t sb[$];
    obs_t ob[$];

    int unsigned ma [N][N];
    int unsigned mb [N][N];

    function automatic logic [31:0] adr(input int region, input int r, input int c);
        logic [1:0] rg;
        rg = 2'(region);
        return {rg, 14'b0, 8'(r), 8'(c)};
    endfunction

    function automatic logic [31:0] model_c(input int r, input int c);
        longint unsigned s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s = s + longint'(ma[r][k]) * longint'(mb[k][c]);
`ifdef AI_ACC_SATURATE_EN
            if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
            s = s & 64'hFFFF_FFFF;
`endif
        end
        return s[31:0];
    endfunction

    // One bus access: expectation queued, response captured one edge later
    task automatic acc(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic eack, input logic [31:0] edata, input bit chk,
                       output logic [31:0] rd);
        exp_t e;
        obs_t o;
        e.name = nm; e.ack = eack; e.data = edata; e.chk = chk;
        sb.push_back(e);
        @(negedge clk);
        bus.wishbone_we_i   = we;
        bus.wishbone_addr_i = a;
        bus.wishbone_data_i = wd;
        @(posedge clk);
        #1;
        o.ack  = bus.wishbone_ack;
        o.data = bus.wishbone_data_o;
        ob.push_back(o);
        rd = o.data;
        bus.wishbone_we_i = 1'b0;
    endtask

    task automatic load_mats();
        logic [31:0] rd;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                acc("wr_a", 1'b1, adr(1, r, c), ma[r][c], 1'b1, 32'h0, 1'b0, rd);
                acc("wr_b", 1'b1, adr(2, r, c), mb[r][c], 1'b1, 32'h0, 1'b0, rd);
            end
    endtask

    // Polls status; done must first appear on poll number first_done
    task automatic wait_done(input int first_done);
        logic [31:0] rd;
        int idx;
        idx = 1;
        do begin
            acc("status_poll", 1'b0, adr(0, 0, 0), 32'h0, 1'b1,
                (idx < first_done) ? 32'h1 : 32'h2, 1'b1, rd);
            idx++;
        end while (rd !== 32'h2 && idx <= 200);
    endtask

    task automatic start_and_wait();
        logic [31:0] rd;
        acc("start", 1'b1, adr(0, 0, 0), 32'h1, 1'b1, 32'h0, 1'b0, rd);
        wait_done(N * N * N + 2);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        exp_t e;
        obs_t o;
        bus.wishbone_we_i = 1'b0; bus.wishbone_addr_i = '0; bus.wishbone_data_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.wishbone_ack !== 1'b0 || bus.wishbone_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%0b data=%08h expected ack=0 data=00000000",
                     bus.wishbone_ack, bus.wishbone_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        acc("reset_status", 1'b0, adr(0, 0, 0), 32'h0, 1'b1, 32'h0, 1'b1, rd);
        for (int rg = 1; rg < 4; rg++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    acc("reset_mem", 1'b0, adr(rg, r, c), 32'h0, 1'b1, 32'h0, 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    task automatic test_load_compute();
        logic [31:0] rd;
        exp_t e;
        obs_t o;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 32'hAAAA; mb[r][c] = 32'h5555;
            end
        load_mats();
        start_and_wait();
        acc("done_sticky", 1'b0, adr(0, 0, 0), 32'h0, 1'b1, 32'h2, 1'b1, rd);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc("c_aaaa_5555", 1'b0, adr(3, r, c), 32'h0, 1'b1, 32'hE38C71C8, 1'b1, rd);
        acc("rd_a_back", 1'b0, adr(1, 2, 3), 32'h0, 1'b1, 32'h0000AAAA, 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    task automatic test_identity();
        logic [31:0] rd;
        exp_t e;
        obs_t o;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 1 : 0; mb[r][c] = 16 * r + c;
            end
        load_mats();
        start_and_wait();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc("c_identity", 1'b0, adr(3, r, c), 32'h0, 1'b1, mb[r][c], 1'b1, rd);
        acc("wr_c_ignored", 1'b1, adr(3, 1, 1), 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, rd);
        acc("rd_c_after_wr", 1'b0, adr(3, 1, 1), 32'h0, 1'b1, mb[1][1], 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] want;
        exp_t e;
        obs_t o;
`ifdef AI_ACC_SATURATE_EN
        want = 32'hFFFF_FFFF;
`else
        want = 32'hFFF8_0004;
`endif
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 32'hFFFF; mb[r][c] = 32'hFFFF;
            end
        load_mats();
        start_and_wait();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc("c_overflow", 1'b0, adr(3, r, c), 32'h0, 1'b1, want, 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    task automatic test_busy_protect();
        logic [31:0] rd;
        exp_t e;
        obs_t o;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r * 37 + c * 11 + 5) & 16'hFFFF;
                mb[r][c] = (r * 1013 + c * 7 + 3) & 16'hFFFF;
            end
        load_mats();
        acc("start", 1'b1, adr(0, 0, 0), 32'h1, 1'b1, 32'h0, 1'b0, rd);
        acc("wr_a_busy", 1'b1, adr(1, 0, 0), 32'h1234, 1'b0, 32'h0, 1'b0, rd);
        acc("start_busy", 1'b1, adr(0, 0, 0), 32'h1, 1'b0, 32'h0, 1'b0, rd);
        wait_done(N * N * N);
        acc("a00_kept", 1'b0, adr(1, 0, 0), 32'h0, 1'b1, ma[0][0], 1'b1, rd);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc("c_busy_result", 1'b0, adr(3, r, c), 32'h0, 1'b1, model_c(r, c), 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        exp_t e;
        obs_t o;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = r + c + 1; mb[r][c] = 2 * r + 3 * c + 1;
            end
        load_mats();
        acc("start", 1'b1, adr(0, 0, 0), 32'h1, 1'b1, 32'h0, 1'b0, rd);
        for (int n = 0; n < 10; n++)
            acc("status_running", 1'b0, adr(0, 0, 0), 32'h0, 1'b1, 32'h1, 1'b1, rd);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.wishbone_ack !== 1'b0 || bus.wishbone_data_o !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: ack=%0b data=%08h expected ack=0 data=00000000",
                     bus.wishbone_ack, bus.wishbone_data_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc("status_after_rst", 1'b0, adr(0, 0, 0), 32'h0, 1'b1, 32'h0, 1'b1, rd);
        for (int rg = 1; rg < 4; rg++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    acc("mem_after_rst", 1'b0, adr(rg, r, c), 32'h0, 1'b1, 32'h0, 1'b1, rd);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 3 : 0; mb[r][c] = 100 * r + c;
            end
        load_mats();
        start_and_wait();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc("c_after_rst", 1'b0, adr(3, r, c), 32'h0, 1'b1, model_c(r, c), 1'b1, rd);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); total++;
            if (o.ack !== e.ack || (e.chk && o.data !== e.data)) begin
                bad++;
                $display("FAIL %s: ack=%0b data=%08h expected ack=%0b data=%08h",
                         e.name, o.ack, o.data, e.ack, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_compute();
        test_identity();
        test_overflow();
        test_busy_protect();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
